// File: rtl/display_scan.sv
// Time-multiplexed scan controller for a 4-digit 7-segment display.
// New values are shadowed and committed only at frame end so a frame never mixes digits.
module display_scan #(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] num,
  input  logic        load,
  input  logic        lz_en,
  output logic        ready,
  output logic [1:0]  digit,
  output logic [3:0]  hexval,
  output logic        blank,
  output logic        frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   shad_q, shad_d;
  logic          pend_q, pend_d;
  logic          lz_q;
  logic          slot_end_s;
  logic          commit_s;
  logic          supp_s;

  assign slot_end_s = (cnt_q == CW'(DIV - 1));
  assign commit_s   = slot_end_s && (dig_q == 2'd3);

  // Next-state: slot counter, digit walk, commit and load handshake
  always_comb begin
    cnt_d  = cnt_q;
    dig_d  = dig_q;
    disp_d = disp_q;
    shad_d = shad_q;
    pend_d = pend_q;
    if (slot_end_s) begin
      cnt_d = '0;
      dig_d = dig_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
      dig_d = dig_q;
    end
    // commit needs pend=1 and load needs pend=0, so the branches never collide
    if (commit_s && pend_q) begin
      disp_d = shad_q;
      pend_d = 1'b0;
    end else if (load && !pend_q) begin
      shad_d = num;
      pend_d = 1'b1;
    end else begin
      disp_d = disp_q;
      shad_d = shad_q;
      pend_d = pend_q;
    end
  end

  // State registers; lz_en is registered so no input reaches an output combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      dig_q  <= 2'd0;
      disp_q <= 16'h0000;
      shad_q <= 16'h0000;
      pend_q <= 1'b0;
      lz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      disp_q <= disp_d;
      shad_q <= shad_d;
      pend_q <= pend_d;
      lz_q   <= lz_en;
    end
  end

  // Output decode from registered state only
  always_comb begin
    supp_s = 1'b0;
    hexval = 4'h0;
    case (dig_q)
      2'd0: begin
        supp_s = 1'b0;
        hexval = disp_q[3:0];
      end
      2'd1: begin
        supp_s = lz_q && (disp_q[15:4] == 12'h000);
        hexval = disp_q[7:4];
      end
      2'd2: begin
        supp_s = lz_q && (disp_q[15:8] == 8'h00);
        hexval = disp_q[11:8];
      end
      2'd3: begin
        supp_s = lz_q && (disp_q[15:12] == 4'h0);
        hexval = disp_q[15:12];
      end
      default: begin
        supp_s = 1'b0;
        hexval = 4'h0;
      end
    endcase
    blank      = (cnt_q < CW'(BLANK)) || supp_s;
    digit      = dig_q;
    ready      = ~pend_q;
    frame_done = commit_s;
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan (DIV=8, BLANK=2) with a queue of committed values.
module tb_display_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] num;
  logic        load;
  logic        lz_en;
  logic        ready;
  logic [1:0]  digit;
  logic [3:0]  hexval;
  logic        blank;
  logic        frame_done;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb_q[$];
  logic [15:0] shown = 16'h0000;

  display_scan #(.DIV(8), .BLANK(2)) dut (
    .clk(clk), .reset(reset), .num(num), .load(load), .lz_en(lz_en),
    .ready(ready), .digit(digit), .hexval(hexval), .blank(blank),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks one full frame starting at slot 0 cycle 0; optionally issues a load / ignored load.
  task automatic frame_check(input logic lz, input int load_at, input logic [15:0] load_val,
                             input int ign_at);
    logic [15:0] v;
    logic        sup;
    int          d;
    int          c;
    if (sb_q.size() > 0) shown = sb_q.pop_front();
    v = shown;
    for (int i = 0; i < 32; i++) begin
      d   = i / 8;
      c   = i % 8;
      sup = lz && ((d == 3 && v[15:12] == 4'h0) || (d == 2 && v[15:8] == 8'h00) ||
                   (d == 1 && v[15:4] == 12'h000));
      chk("digit", 16'(digit), 16'(d));
      chk("hexval", 16'(hexval), 16'(v[4*d +: 4]));
      chk("blank", 16'(blank), 16'((c < 2) || sup));
      chk("frame_done", 16'(frame_done), 16'(i == 31));
      if (load_at >= 0 && i == load_at) begin
        chk("ready_before_load", 16'(ready), 16'd1);
        load = 1'b1;
        num  = load_val;
        sb_q.push_back(load_val);
      end
      if (load_at >= 0 && i == load_at + 1) begin
        chk("ready_after_load", 16'(ready), 16'd0);
        load = 1'b0;
      end
      if (ign_at >= 0 && i == ign_at) begin
        chk("ready_low_ignored", 16'(ready), 16'd0);
        load = 1'b1;
        num  = 16'hABCD;
      end
      if (ign_at >= 0 && i == ign_at + 2) load = 1'b0;
      if (load_at >= 0 && i == 31) chk("ready_commit_cycle", 16'(ready), 16'd0);
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    num   = 16'h0000;
    load  = 1'b0;
    lz_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_digit", 16'(digit), 16'd0);
      chk("rst_blank", 16'(blank), 16'd1);
      chk("rst_ready", 16'(ready), 16'd1);
      chk("rst_hexval", 16'(hexval), 16'd0);
      chk("rst_frame_done", 16'(frame_done), 16'd0);
    end
    reset = 1'b0;

    // Scan with zero; load 1234 in digit-1 slot, then an ignored ABCD load while pending
    frame_check(1'b0, 9, 16'h1234, 20);
    // Shows 1234 (not ABCD); back-to-back load of ABCD in first ready cycle
    chk("ready_after_commit", 16'(ready), 16'd1);
    lz_en = 1'b1;
    frame_check(1'b0, 0, 16'hABCD, -1);
    frame_check(1'b1, 0, 16'h0050, -1);
    frame_check(1'b1, 0, 16'h0000, -1);
    frame_check(1'b1, -1, 16'h0000, -1);
    lz_en = 1'b0;
    frame_check(1'b0, -1, 16'h0000, -1);

    // Reset while a value is pending in the digit-2 slot
    frame_check(1'b0, 0, 16'h4321, -1);
    chk("mid_ready_pre", 16'(ready), 16'd1);
    load = 1'b1;
    num  = 16'h9999;
    step();
    load = 1'b0;
    chk("mid_ready_pend", 16'(ready), 16'd0);
    for (int i = 0; i < 16; i++) step();
    chk("mid_digit2", 16'(digit), 16'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_digit", 16'(digit), 16'd0);
    chk("mid_ready", 16'(ready), 16'd1);
    chk("mid_hexval", 16'(hexval), 16'd0);
    chk("mid_blank", 16'(blank), 16'd1);
    chk("mid_frame_done", 16'(frame_done), 16'd0);
    sb_q.delete();
    shown = 16'h0000;
    frame_check(1'b0, -1, 16'h0000, -1);
    frame_check(1'b0, -1, 16'h0000, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
